// File: rtl/mem_bus_master_if.sv
// Ram_STB/Ram_ACK bus between the CPU memory access unit and the RAM wait-state responder.
// The master drives the strobed cycle; the slave returns registered ACK and read data.
interface mem_bus_master_if #(
  parameter int ADDR_W = 32
) ();
  logic              Ram_STB;
  logic              Ram_WE;
  logic [ADDR_W-1:0] Ram_ADDR;
  logic [3:0]        Ram_SEL;
  logic [31:0]       Ram_DAT_O;
  logic [31:0]       Ram_DAT_I;
  logic              Ram_ACK;

  modport master (
    output Ram_STB, Ram_WE, Ram_ADDR, Ram_SEL, Ram_DAT_O,
    input  Ram_DAT_I, Ram_ACK
  );

  modport slave (
    input  Ram_STB, Ram_WE, Ram_ADDR, Ram_SEL, Ram_DAT_O,
    output Ram_DAT_I, Ram_ACK
  );
endinterface

// File: rtl/mem_bus_master.sv
// CPU-side memory access unit: turns one load/store request into one strobed bus cycle,
// steering byte/half lanes, extending load data and aborting cycles that never get ACK.
//
// Handshake: the CPU holds cpu_req and its operands stable while cpu_stall=1; the result
// is a single-cycle cpu_done or cpu_err pulse, during which cpu_stall=0. On the bus,
// Ram_STB stays high with stable outputs until a cycle with Ram_ACK=1 (or timeout), and
// always drops for at least one cycle between transactions.
module mem_bus_master #(
  parameter int TIMEOUT = 63,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [1:0]        state_dbg,
  mem_bus_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        tmo_cnt;
  logic              stb_q;
  logic              we_bus_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_o_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              uns_q;
  logic              we_q;

  logic              req_illegal;
  logic              timeout_hit;
  logic [3:0]        sel_d;
  logic [31:0]       dat_o_d;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_ext;

  assign req_illegal = (cpu_size == 2'b11)
                     | ((cpu_size == 2'b01) & cpu_addr[0])
                     | ((cpu_size == 2'b10) & (cpu_addr[1:0] != 2'b00));
  assign timeout_hit = (tmo_cnt == TMO_LAST);

  // Next-state logic; ACK takes priority over the timeout on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cpu_req) state_d = req_illegal ? S_DONE : S_BUS;
      S_BUS:  if (bus.Ram_ACK || timeout_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Write lane steering from the live request, captured on entry to BUS.
  always_comb begin
    sel_d   = 4'hF;
    dat_o_d = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        sel_d   = 4'b0001 << cpu_addr[1:0];
        dat_o_d = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        sel_d   = cpu_addr[1] ? 4'b1100 : 4'b0011;
        dat_o_d = {2{cpu_wdata[15:0]}};
      end
      default: begin
        sel_d   = 4'hF;
        dat_o_d = cpu_wdata;
      end
    endcase
  end

  // Read lane selection and extension from the latched request.
  always_comb begin
    byte_lane = bus.Ram_DAT_I[7:0];
    case (off_q)
      2'd1:    byte_lane = bus.Ram_DAT_I[15:8];
      2'd2:    byte_lane = bus.Ram_DAT_I[23:16];
      2'd3:    byte_lane = bus.Ram_DAT_I[31:24];
      default: byte_lane = bus.Ram_DAT_I[7:0];
    endcase
    half_lane = off_q[1] ? bus.Ram_DAT_I[31:16] : bus.Ram_DAT_I[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: load_ext = bus.Ram_DAT_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      stb_q     <= 1'b0;
      we_bus_q  <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      dat_o_q   <= '0;
      size_q    <= '0;
      off_q     <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            if (req_illegal) begin
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              stb_q    <= 1'b1;
              we_bus_q <= cpu_we;
              addr_q   <= {cpu_addr[ADDR_W-1:2], 2'b00};
              sel_q    <= sel_d;
              dat_o_q  <= dat_o_d;
              size_q   <= cpu_size;
              off_q    <= cpu_addr[1:0];
              uns_q    <= cpu_unsigned;
              we_q     <= cpu_we;
              tmo_cnt  <= '0;
            end
          end
        end
        S_BUS: begin
          if (bus.Ram_ACK) begin
            stb_q     <= 1'b0;
            we_bus_q  <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_rdata <= we_q ? 32'h0 : load_ext;
          end else if (timeout_hit) begin
            stb_q     <= 1'b0;
            we_bus_q  <= 1'b0;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall     = ((state_q == S_IDLE) && cpu_req) || (state_q == S_BUS);
  assign state_dbg     = state_q;
  assign bus.Ram_STB   = stb_q;
  assign bus.Ram_WE    = we_bus_q;
  assign bus.Ram_ADDR  = addr_q;
  assign bus.Ram_SEL   = sel_q;
  assign bus.Ram_DAT_O = dat_o_q;

endmodule
